// File: rtl/seven_seg_loader.sv
// Debounces a load button, snapshots a 32-bit word on each press and writes it
// one nibble per digit into the seven_seg display (write/select/num strobes).
module seven_seg_loader #(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int GAP_CYCLES      = 4,
   parameter int DIGITS          = 8
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        btn,
   input  logic [31:0] data,
   output logic        write,
   output logic [2:0]  select,
   output logic [3:0]  num,
   output logic        busy,
   output logic        done
);

   localparam int CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam int GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [GAP_W-1:0] GAP_END  = GAP_W'(GAP_LAST);
   localparam logic [2:0]       IDX_LAST = 3'(DIGITS - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WRITE,
      S_GAP,
      S_DONE
   } state_t;

   function automatic logic [3:0] nibble(input logic [31:0] word, input logic [2:0] k);
      return word[{k, 2'b00} +: 4];
   endfunction

   logic             r_sync1;
   logic             r_sync2;
   logic             r_stable;
   logic             r_stable_d;
   logic             r_load_req;
   logic [CNT_W-1:0] r_cnt;

   // btn is asynchronous: two flops before anything looks at it
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_sync1    <= 1'b0;
         r_sync2    <= 1'b0;
         r_stable   <= 1'b0;
         r_stable_d <= 1'b0;
         r_load_req <= 1'b0;
         r_cnt      <= '0;
      end else begin
         r_sync1    <= btn;
         r_sync2    <= r_sync1;
         r_stable_d <= r_stable;
         r_load_req <= r_stable & ~r_stable_d;
         if (r_sync2 == r_stable) begin
            r_cnt <= '0;
         end else if (r_cnt == CNT_LAST) begin
            r_stable <= r_sync2;
            r_cnt    <= '0;
         end else begin
            r_cnt <= r_cnt + CNT_W'(1);
         end
      end
   end

   state_t           r_state;
   state_t           w_state_nxt;
   logic [2:0]       r_idx;
   logic [2:0]       w_idx_nxt;
   logic [2:0]       w_idx_inc;
   logic [GAP_W-1:0] r_gap;
   logic [GAP_W-1:0] w_gap_nxt;
   logic [31:0]      r_shadow;
   logic [31:0]      w_shadow_nxt;
   logic             r_write;
   logic             w_write_nxt;
   logic [2:0]       r_select;
   logic [2:0]       w_select_nxt;
   logic [3:0]       r_num;
   logic [3:0]       w_num_nxt;
   logic             r_busy;
   logic             r_done;
   logic             w_done_nxt;

   assign w_idx_inc = r_idx + 3'd1;

   // Outputs are computed for the next state so they register in step with it
   always_comb begin
      w_state_nxt  = r_state;
      w_idx_nxt    = r_idx;
      w_gap_nxt    = r_gap;
      w_shadow_nxt = r_shadow;
      w_write_nxt  = 1'b0;
      w_select_nxt = r_select;
      w_num_nxt    = r_num;
      w_done_nxt   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (r_load_req) begin
               w_shadow_nxt = data;
               w_idx_nxt    = '0;
               w_state_nxt  = S_WRITE;
               w_write_nxt  = 1'b1;
               w_select_nxt = '0;
               w_num_nxt    = data[3:0];
            end
         end
         S_WRITE: begin
            if (r_idx == IDX_LAST) begin
               w_state_nxt = S_DONE;
               w_done_nxt  = 1'b1;
            end else begin
               w_idx_nxt = w_idx_inc;
               if (GAP_CYCLES == 0) begin
                  w_state_nxt  = S_WRITE;
                  w_write_nxt  = 1'b1;
                  w_select_nxt = w_idx_inc;
                  w_num_nxt    = nibble(r_shadow, w_idx_inc);
               end else begin
                  w_state_nxt = S_GAP;
                  w_gap_nxt   = '0;
               end
            end
         end
         S_GAP: begin
            if (r_gap == GAP_END) begin
               w_state_nxt  = S_WRITE;
               w_write_nxt  = 1'b1;
               w_select_nxt = r_idx;
               w_num_nxt    = nibble(r_shadow, r_idx);
            end else begin
               w_gap_nxt = r_gap + GAP_W'(1);
            end
         end
         S_DONE: begin
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state  <= S_IDLE;
         r_idx    <= '0;
         r_gap    <= '0;
         r_shadow <= '0;
         r_write  <= 1'b0;
         r_select <= '0;
         r_num    <= '0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_idx    <= w_idx_nxt;
         r_gap    <= w_gap_nxt;
         r_shadow <= w_shadow_nxt;
         r_write  <= w_write_nxt;
         r_select <= w_select_nxt;
         r_num    <= w_num_nxt;
         r_busy   <= (w_state_nxt != S_IDLE);
         r_done   <= w_done_nxt;
      end
   end

   assign write  = r_write;
   assign select = r_select;
   assign num    = r_num;
   assign busy   = r_busy;
   assign done   = r_done;

endmodule

// File: tb/tb_seven_seg_loader.sv
// Bench for seven_seg_loader: three instances (GAP=2/DIGITS=8, GAP=0, DIGITS=1) share inputs;
// observed write/done events are compared against a schedule computed from the load timing rules.
module tb_seven_seg_loader;

   localparam int DEB      = 4;
   localparam int GAP      = 2;
   localparam int DIG      = 8;
   localparam int RUN_BUSY = DIG + (DIG - 1) * GAP + 1;

   typedef struct packed {
      int         c;
      logic [2:0] sel;
      logic [3:0] nib;
   } ev_t;

   logic        clock   = 1'b0;
   logic        reset_n = 1'b1;
   logic        btn     = 1'b0;
   logic [31:0] data    = '0;

   logic       wr_m, busy_m, done_m, wr_g, busy_g, done_g, wr_d, busy_d, done_d;
   logic [2:0] sel_m, sel_g, sel_d;
   logic [3:0] num_m, num_g, num_d;

   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;
   ev_t  wq_m[$], wq_g[$], wq_d[$];
   int   dq_m[$], dq_g[$], dq_d[$];
   int   bc_m = 0, bc_g = 0, bc_d = 0;
   ev_t  exp_q[$];
   int   exp_done;

   seven_seg_loader #(.DEBOUNCE_CYCLES(DEB), .GAP_CYCLES(GAP), .DIGITS(DIG)) dut (
      .clock(clock), .reset_n(reset_n), .btn(btn), .data(data),
      .write(wr_m), .select(sel_m), .num(num_m), .busy(busy_m), .done(done_m));

   seven_seg_loader #(.DEBOUNCE_CYCLES(DEB), .GAP_CYCLES(0), .DIGITS(DIG)) dut_g0 (
      .clock(clock), .reset_n(reset_n), .btn(btn), .data(data),
      .write(wr_g), .select(sel_g), .num(num_g), .busy(busy_g), .done(done_g));

   seven_seg_loader #(.DEBOUNCE_CYCLES(DEB), .GAP_CYCLES(GAP), .DIGITS(1)) dut_d1 (
      .clock(clock), .reset_n(reset_n), .btn(btn), .data(data),
      .write(wr_d), .select(sel_d), .num(num_d), .busy(busy_d), .done(done_d));

   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   always @(negedge clock) begin
      if (wr_m)   wq_m.push_back({cyc, sel_m, num_m});
      if (wr_g)   wq_g.push_back({cyc, sel_g, num_g});
      if (wr_d)   wq_d.push_back({cyc, sel_d, num_d});
      if (done_m) dq_m.push_back(cyc);
      if (done_g) dq_g.push_back(cyc);
      if (done_d) dq_d.push_back(cyc);
      if (busy_m) bc_m <= bc_m + 1;
      if (busy_g) bc_g <= bc_g + 1;
      if (busy_d) bc_d <= bc_d + 1;
   end

   // A press whose btn rises just before edge t0+1 reaches the synchronizer output at t0+2,
   // is accepted after DEB stable cycles, then costs one load_req cycle and one snapshot edge.
   function automatic void model_run(input int t0, input logic [31:0] d, input int gap, input int dig);
      int first;
      first = t0 + 2 + DEB + 2;
      exp_q.delete();
      for (int k = 0; k < dig; k++) exp_q.push_back({first + k * (gap + 1), 3'(k), d[4*k +: 4]});
      exp_done = first + (dig - 1) * (gap + 1) + 1;
   endfunction

   task automatic tick(input int n);
      repeat (n) begin
         @(negedge clock);
         #1;
      end
   endtask

   task automatic test_reset();
      int t0, ws, ds;
      tick(2);
      btn = 1'b1;
      data = 32'h1357_9BDF;
      reset_n = 1'b0;
      ws = wq_m.size();
      tick(6);
      checks++; if (wr_m !== 1'b0)   begin failures++; $display("FAIL reset_write: got %b required 0", wr_m); end
      checks++; if (sel_m !== 3'd0)  begin failures++; $display("FAIL reset_select: got %0d required 0", sel_m); end
      checks++; if (num_m !== 4'd0)  begin failures++; $display("FAIL reset_num: got %h required 0", num_m); end
      checks++; if (busy_m !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b required 0", busy_m); end
      checks++; if (done_m !== 1'b0) begin failures++; $display("FAIL reset_done: got %b required 0", done_m); end
      checks++; if (wq_m.size() != ws) begin failures++; $display("FAIL reset_no_write: got %0d writes required 0", wq_m.size() - ws); end
      ws = wq_m.size();
      ds = dq_m.size();
      reset_n = 1'b1;
      t0 = cyc;
      model_run(t0, data, GAP, DIG);
      for (int i = 0; i < 400 && dq_m.size() == ds; i++) tick(1);
      checks++;
      if (dq_m.size() == ds) begin failures++; $display("FAIL reset_load_done: none within budget, required cycle %0d", exp_done); end
      else if (dq_m[ds] != exp_done) begin failures++; $display("FAIL reset_load_done: cycle %0d required %0d", dq_m[ds], exp_done); end
      checks++;
      if (wq_m.size() - ws != exp_q.size()) begin
         failures++; $display("FAIL reset_load_count: got %0d writes required %0d", wq_m.size() - ws, exp_q.size());
      end else foreach (exp_q[k]) begin
         checks++;
         if (wq_m[ws+k] !== exp_q[k]) begin
            failures++;
            $display("FAIL reset_load_write%0d: got c=%0d sel=%0d num=%h required c=%0d sel=%0d num=%h", k,
                     wq_m[ws+k].c, wq_m[ws+k].sel, wq_m[ws+k].nib, exp_q[k].c, exp_q[k].sel, exp_q[k].nib);
         end
      end
      btn = 1'b0;
      tick(DEB + 6);
   endtask

   task automatic test_load_random();
      for (int it = 0; it < 4; it++) begin
         int t0, ws, ds, bs, nb;
         logic [31:0] d;
         d = (it == 0) ? 32'h89AB_CDEF : $urandom;
         data = d;
         tick($urandom_range(1, 5));
         nb = (it == 0) ? 0 : $urandom_range(0, 3);
         for (int b = 0; b < nb; b++) begin
            btn = 1'b1; tick($urandom_range(1, DEB - 1));
            btn = 1'b0; tick($urandom_range(1, 3));
         end
         ws = wq_m.size(); ds = dq_m.size(); bs = bc_m;
         btn = 1'b1;
         t0 = cyc;
         model_run(t0, d, GAP, DIG);
         tick(DEB + 5);
         data = $urandom;
         for (int i = 0; i < 400 && dq_m.size() == ds; i++) tick(1);
         tick(2);
         checks++;
         if (dq_m.size() == ds) begin failures++; $display("FAIL load%0d_done: none within budget, required cycle %0d", it, exp_done); end
         else if (dq_m[ds] != exp_done) begin failures++; $display("FAIL load%0d_done: cycle %0d required %0d", it, dq_m[ds], exp_done); end
         checks++;
         if (bc_m - bs != RUN_BUSY) begin failures++; $display("FAIL load%0d_busy: %0d busy cycles required %0d", it, bc_m - bs, RUN_BUSY); end
         checks++;
         if (wq_m.size() - ws != exp_q.size()) begin
            failures++; $display("FAIL load%0d_count: got %0d writes required %0d", it, wq_m.size() - ws, exp_q.size());
         end else foreach (exp_q[k]) begin
            checks++;
            if (wq_m[ws+k] !== exp_q[k]) begin
               failures++;
               $display("FAIL load%0d_write%0d: got c=%0d sel=%0d num=%h required c=%0d sel=%0d num=%h", it, k,
                        wq_m[ws+k].c, wq_m[ws+k].sel, wq_m[ws+k].nib, exp_q[k].c, exp_q[k].sel, exp_q[k].nib);
            end
         end
         btn = 1'b0;
         tick(DEB + 4);
      end
   endtask

   task automatic test_glitch();
      int ws, bs;
      ws = wq_m.size(); bs = bc_m;
      for (int i = 0; i < 15; i++) begin
         btn = ~btn;
         tick(2);
      end
      btn = 1'b0;
      tick(2);
      for (int i = 0; i < 6; i++) begin
         btn = 1'b1; tick($urandom_range(1, DEB - 1));
         btn = 1'b0; tick($urandom_range(1, 4));
      end
      tick(30);
      checks++; if (wq_m.size() != ws) begin failures++; $display("FAIL glitch_writes: got %0d required 0", wq_m.size() - ws); end
      checks++; if (bc_m != bs)        begin failures++; $display("FAIL glitch_busy: got %0d busy cycles required 0", bc_m - bs); end
   endtask

   task automatic test_busy_drop();
      int t0, ws, ds;
      logic [31:0] d;
      d = $urandom;
      data = d;
      ws = wq_m.size(); ds = dq_m.size();
      btn = 1'b1;
      t0 = cyc;
      model_run(t0, d, GAP, DIG);
      tick(DEB + 5);
      btn = 1'b0;
      tick(DEB + 3);
      data = 32'h0;
      btn = 1'b1;
      for (int i = 0; i < 400 && dq_m.size() == ds; i++) tick(1);
      checks++;
      if (dq_m.size() == ds) begin failures++; $display("FAIL drop_done: none within budget, required cycle %0d", exp_done); end
      else if (dq_m[ds] != exp_done) begin failures++; $display("FAIL drop_done: cycle %0d required %0d", dq_m[ds], exp_done); end
      checks++;
      if (wq_m.size() - ws != exp_q.size()) begin
         failures++; $display("FAIL drop_count: got %0d writes required %0d", wq_m.size() - ws, exp_q.size());
      end else foreach (exp_q[k]) begin
         checks++;
         if (wq_m[ws+k] !== exp_q[k]) begin
            failures++;
            $display("FAIL drop_write%0d: got c=%0d sel=%0d num=%h required c=%0d sel=%0d num=%h", k,
                     wq_m[ws+k].c, wq_m[ws+k].sel, wq_m[ws+k].nib, exp_q[k].c, exp_q[k].sel, exp_q[k].nib);
         end
      end
      tick(20);
      checks++; if (wq_m.size() - ws != DIG) begin failures++; $display("FAIL drop_no_retrigger: got %0d writes required %0d", wq_m.size() - ws, DIG); end
      checks++; if (dq_m.size() - ds != 1)   begin failures++; $display("FAIL drop_single_done: got %0d done pulses required 1", dq_m.size() - ds); end
      btn = 1'b0;
      tick(DEB + 4);
   endtask

   task automatic test_reset_abort();
      int t0, ws, ds;
      logic [31:0] d;
      data = $urandom;
      ws = wq_m.size();
      btn = 1'b1;
      for (int i = 0; i < 200 && wq_m.size() - ws < 3; i++) tick(1);
      checks++; if (wr_m !== 1'b1) begin failures++; $display("FAIL abort_third_write: write=%b required 1", wr_m); end
      reset_n = 1'b0;
      #1;
      checks++; if (wr_m !== 1'b0)   begin failures++; $display("FAIL abort_write_async: got %b required 0", wr_m); end
      checks++; if (busy_m !== 1'b0) begin failures++; $display("FAIL abort_busy_async: got %b required 0", busy_m); end
      checks++; if (sel_m !== 3'd0)  begin failures++; $display("FAIL abort_select_async: got %0d required 0", sel_m); end
      btn = 1'b0;
      tick(3);
      reset_n = 1'b1;
      tick(DEB + 4);
      checks++; if (wq_m.size() - ws != 3) begin failures++; $display("FAIL abort_no_resume: got %0d writes required 3", wq_m.size() - ws); end
      d = $urandom;
      data = d;
      ws = wq_m.size(); ds = dq_m.size();
      btn = 1'b1;
      t0 = cyc;
      model_run(t0, d, GAP, DIG);
      for (int i = 0; i < 400 && dq_m.size() == ds; i++) tick(1);
      checks++;
      if (dq_m.size() == ds) begin failures++; $display("FAIL restart_done: none within budget, required cycle %0d", exp_done); end
      else if (dq_m[ds] != exp_done) begin failures++; $display("FAIL restart_done: cycle %0d required %0d", dq_m[ds], exp_done); end
      checks++;
      if (wq_m.size() - ws != exp_q.size()) begin
         failures++; $display("FAIL restart_count: got %0d writes required %0d", wq_m.size() - ws, exp_q.size());
      end else foreach (exp_q[k]) begin
         checks++;
         if (wq_m[ws+k] !== exp_q[k]) begin
            failures++;
            $display("FAIL restart_write%0d: got c=%0d sel=%0d num=%h required c=%0d sel=%0d num=%h", k,
                     wq_m[ws+k].c, wq_m[ws+k].sel, wq_m[ws+k].nib, exp_q[k].c, exp_q[k].sel, exp_q[k].nib);
         end
      end
      btn = 1'b0;
      tick(DEB + 4);
   endtask

   task automatic test_gap0_digits1();
      int t0, wsg, dsg, bsg, wsd, dsd, bsd;
      logic [31:0] d;
      d = $urandom;
      data = d;
      wsg = wq_g.size(); dsg = dq_g.size(); bsg = bc_g;
      wsd = wq_d.size(); dsd = dq_d.size(); bsd = bc_d;
      btn = 1'b1;
      t0 = cyc;
      tick(45);
      model_run(t0, d, 0, DIG);
      checks++;
      if (dq_g.size() - dsg != 1) begin failures++; $display("FAIL gap0_done_count: got %0d required 1", dq_g.size() - dsg); end
      else if (dq_g[dsg] != exp_done) begin failures++; $display("FAIL gap0_done: cycle %0d required %0d", dq_g[dsg], exp_done); end
      checks++;
      if (bc_g - bsg != DIG + 1) begin failures++; $display("FAIL gap0_busy: %0d busy cycles required %0d", bc_g - bsg, DIG + 1); end
      checks++;
      if (wq_g.size() - wsg != exp_q.size()) begin
         failures++; $display("FAIL gap0_count: got %0d writes required %0d", wq_g.size() - wsg, exp_q.size());
      end else foreach (exp_q[k]) begin
         checks++;
         if (wq_g[wsg+k] !== exp_q[k]) begin
            failures++;
            $display("FAIL gap0_write%0d: got c=%0d sel=%0d num=%h required c=%0d sel=%0d num=%h", k,
                     wq_g[wsg+k].c, wq_g[wsg+k].sel, wq_g[wsg+k].nib, exp_q[k].c, exp_q[k].sel, exp_q[k].nib);
         end
      end
      model_run(t0, d, GAP, 1);
      checks++;
      if (dq_d.size() - dsd != 1) begin failures++; $display("FAIL dig1_done_count: got %0d required 1", dq_d.size() - dsd); end
      else if (dq_d[dsd] != exp_done) begin failures++; $display("FAIL dig1_done: cycle %0d required %0d", dq_d[dsd], exp_done); end
      checks++;
      if (bc_d - bsd != 2) begin failures++; $display("FAIL dig1_busy: %0d busy cycles required 2", bc_d - bsd); end
      checks++;
      if (wq_d.size() - wsd != 1) begin
         failures++; $display("FAIL dig1_count: got %0d writes required 1", wq_d.size() - wsd);
      end else if (wq_d[wsd] !== exp_q[0]) begin
         failures++;
         $display("FAIL dig1_write: got c=%0d sel=%0d num=%h required c=%0d sel=%0d num=%h",
                  wq_d[wsd].c, wq_d[wsd].sel, wq_d[wsd].nib, exp_q[0].c, exp_q[0].sel, exp_q[0].nib);
      end
      btn = 1'b0;
      tick(DEB + 4);
   endtask

   initial begin
      test_reset();
      test_load_random();
      test_glitch();
      test_busy_drop();
      test_reset_abort();
      test_gap0_digits1();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

endmodule
